// File: rtl/disp_msg_sched_pkg.sv
// disp_msg_sched_pkg: state encodings, owner codes, glyph codes and word packing for the message scheduler
package disp_msg_sched_pkg;
  typedef enum logic [1:0] {ST_BASE = 2'b00, ST_NOTICE = 2'b01, ST_ERROR = 2'b10} state_e;
  localparam logic [1:0] OWN_BASE = 2'b00;
  localparam logic [1:0] OWN_NOTICE = 2'b01;
  localparam logic [1:0] OWN_ERROR = 2'b10;
  localparam logic [4:0] G_0 = 5'h00;
  localparam logic [4:0] G_1 = 5'h01;
  localparam logic [4:0] G_2 = 5'h02;
  localparam logic [4:0] G_3 = 5'h03;
  localparam logic [4:0] G_4 = 5'h04;
  localparam logic [4:0] G_5 = 5'h05;
  localparam logic [4:0] G_6 = 5'h06;
  localparam logic [4:0] G_7 = 5'h07;
  localparam logic [4:0] G_8 = 5'h08;
  localparam logic [4:0] G_9 = 5'h09;
  localparam logic [4:0] G_A = 5'h0A;
  localparam logic [4:0] G_B = 5'h0B;
  localparam logic [4:0] G_C = 5'h0C;
  localparam logic [4:0] G_D = 5'h0D;
  localparam logic [4:0] G_E = 5'h0E;
  localparam logic [4:0] G_F = 5'h0F;
  localparam logic [4:0] G_R = 5'h10;
  localparam logic [4:0] G_T = 5'h11;
  localparam logic [4:0] G_P = 5'h12;
  localparam logic [4:0] G_L = 5'h13;
  localparam logic [4:0] G_J = 5'h14;
  localparam logic [4:0] G_N = 5'h15;
  localparam logic [19:0] RST_CODE = {G_F, G_F, G_F, G_F};
  function automatic logic [19:0] pack4(input logic [4:0] d3, input logic [4:0] d2, input logic [4:0] d1, input logic [4:0] d0);
    return {d3, d2, d1, d0};
  endfunction
endpackage

// File: rtl/disp_msg_sched_tick.sv
// ms_tick_gen: prescaler with sync clear emitting a one-cycle tick every TICK_DIV cycles
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(TICK_DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/disp_msg_sched.sv
// disp_msg_sched: base/notice/error display arbiter with timed hold; DISP_ERR_BLINK_EN enables error blinking
module disp_msg_sched
  import disp_msg_sched_pkg::*;
#(
  parameter int TICK_DIV = 100_000,
  parameter int HOLD_MS = 2000,
  parameter int BLINK_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] base_code,
  input  logic [1:0]  msg_req,
  input  logic [19:0] msg_code1,
  input  logic [19:0] msg_code0,
  input  logic        msg_cancel,
  output logic [1:0]  msg_ack,
  output logic [19:0] disp_code,
  output logic [3:0]  disp_blank,
  output logic [1:0]  owner,
  output logic        busy
);
  state_e state_q, state_d;
  logic [1:0] ack_q, ack_d, owner_q, owner_d;
  logic [19:0] code_q, code_d;
  logic [15:0] hold_q, hold_d;
  logic busy_q, busy_d, blank_q, blank_d;
  logic tick, clr, acc_err, acc_not, expire, leave;
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
  always_comb begin
    acc_err = msg_req[1];
    acc_not = msg_req[0] && !msg_req[1] && (state_q == ST_BASE || (state_q == ST_NOTICE && msg_cancel));
    clr = acc_err || acc_not;
    expire = tick && hold_q == 16'(HOLD_MS - 1);
    leave = state_q != ST_BASE && (msg_cancel || expire);
    state_d = acc_err ? ST_ERROR : acc_not ? ST_NOTICE : leave ? ST_BASE : state_q;
    ack_d = {acc_err, acc_not};
    code_d = acc_err ? msg_code1 : acc_not ? msg_code0 : state_d == ST_BASE ? base_code : code_q;
    hold_d = (clr || state_d == ST_BASE) ? '0 : hold_q + 16'(tick);
    owner_d = state_d == ST_ERROR ? OWN_ERROR : state_d == ST_NOTICE ? OWN_NOTICE : OWN_BASE;
    busy_d = state_d != ST_BASE;
  end
`ifdef DISP_ERR_BLINK_EN
  logic [15:0] blink_q, blink_d;
  logic flip;
  always_comb begin
    flip = tick && blink_q == 16'(BLINK_MS - 1);
    blink_d = (clr || state_d != ST_ERROR || flip) ? '0 : blink_q + 16'(tick);
    blank_d = (clr || state_d != ST_ERROR) ? 1'b0 : blank_q ^ flip;
  end
  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else blink_q <= blink_d;
  end
`else
  logic [15:0] unused_blink_ms;
  assign unused_blink_ms = 16'(BLINK_MS);
  assign blank_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BASE;
      ack_q <= '0;
      owner_q <= OWN_BASE;
      code_q <= RST_CODE;
      hold_q <= '0;
      busy_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      owner_q <= owner_d;
      code_q <= code_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
      blank_q <= blank_d;
    end
  end
  assign msg_ack = ack_q;
  assign disp_code = code_q;
  assign disp_blank = {4{blank_q}};
  assign owner = owner_q;
  assign busy = busy_q;
endmodule
